// File: rtl/mc_port_buffer_pkg.sv
// Shared encodings and entry layouts for the memory-controller port buffer.
package mc_port_buffer_pkg;

  localparam int VADR_W  = 48;
  localparam int DATA_W  = 64;
  localparam int RDCTL_W = 32;

  typedef enum logic [1:0] {
    MC_SZ_1B = 2'd0,
    MC_SZ_2B = 2'd1,
    MC_SZ_4B = 2'd2,
    MC_SZ_8B = 2'd3
  } mc_size_e;

  typedef struct packed {
    logic              ld;
    logic              st;
    mc_size_e          size;
    logic [VADR_W-1:0] vadr;
    logic [DATA_W-1:0] data;
  } req_entry_t;

  typedef struct packed {
    logic [RDCTL_W-1:0] rdctl;
    logic [DATA_W-1:0]  data;
  } rsp_entry_t;

  localparam int REQ_ENTRY_W = $bits(req_entry_t);
  localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

endpackage

// File: rtl/mc_port_buffer_fifo.sv
// Synchronous FIFO with occupancy count; head is visible combinationally on rd_data.
module mc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left uninitialised by reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mc_port_buffer.sv
// In-order request buffer toward the memory controller with credit-limited loads
// and a response buffer returning read data downstream.
module mc_port_buffer
  import mc_port_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKID  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_ld,
  input  logic               req_st,
  input  logic [1:0]         req_size,
  input  logic [VADR_W-1:0]  req_vadr,
  input  logic [DATA_W-1:0]  req_data,
  output logic               mc_req_ld,
  output logic               mc_req_st,
  output logic [1:0]         mc_req_size,
  output logic [VADR_W-1:0]  mc_req_vadr,
  output logic [DATA_W-1:0]  mc_req_wrd_rdctl,
  input  logic               mc_rd_rq_stall,
  input  logic               mc_wr_rq_stall,
  input  logic               mc_rsp_push,
  input  logic [DATA_W-1:0]  mc_rsp_data,
  input  logic [RDCTL_W-1:0] mc_rsp_rdctl,
  output logic               mc_rsp_stall,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [RDCTL_W-1:0] rsp_rdctl,
  output logic               idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  req_entry_t             req_wr_entry;
  req_entry_t             req_head;
  logic [REQ_ENTRY_W-1:0] req_head_bits;
  logic [CW-1:0]          req_count;
  logic                   req_full, req_empty, req_push;

  rsp_entry_t             rsp_head;
  logic [RSP_ENTRY_W-1:0] rsp_head_bits;
  logic [CW-1:0]          rsp_count;
  logic                   rsp_full, rsp_empty, rsp_pop;

  req_entry_t             mc_out_q, mc_out_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic                   rsp_stall_q, rsp_stall_d;
  logic                   ready_en_q, ready_en_d;

  logic [CW:0]            credit_used;
  logic                   credit_ok, ld_go, st_go, issue, rsp_dec;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready and the head/payload is stable while valid.
  assign req_ready = !req_full && ready_en_q && !reset;
  assign req_push  = req_valid && req_ready;

  assign req_wr_entry = '{ld: req_ld, st: req_st, size: mc_size_e'(req_size),
                          vadr: req_vadr, data: req_data};
  assign req_head = req_head_bits;

  mc_sync_fifo #(.WIDTH(REQ_ENTRY_W), .DEPTH(DEPTH)) u_req_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (req_push),
    .wr_data (req_wr_entry),
    .pop     (issue),
    .rd_data (req_head_bits),
    .count   (req_count),
    .full    (req_full),
    .empty   (req_empty)
  );

  assign rsp_valid = !rsp_empty && !reset;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_head_bits;
  assign rsp_data  = rsp_head.data;
  assign rsp_rdctl = rsp_head.rdctl;

  mc_sync_fifo #(.WIDTH(RSP_ENTRY_W), .DEPTH(DEPTH)) u_rsp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (mc_rsp_push),
    .wr_data ({mc_rsp_rdctl, mc_rsp_data}),
    .pop     (rsp_pop),
    .rd_data (rsp_head_bits),
    .count   (rsp_count),
    .full    (rsp_full),
    .empty   (rsp_empty)
  );

  // A load may only go out if its response is guaranteed a slot in the response FIFO.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, rsp_count};
  assign credit_ok   = credit_used < (CW+1)'(DEPTH);
  assign ld_go       = !req_empty && req_head.ld && !mc_rd_rq_stall && credit_ok;
  assign st_go       = !req_empty && !req_head.ld && !mc_wr_rq_stall;
  assign issue       = ld_go || st_go;
  assign rsp_dec     = mc_rsp_push && (outstanding_q != '0);

  always_comb begin
    mc_out_d      = '0;
    outstanding_d = outstanding_q;
    rsp_stall_d   = (rsp_count >= CW'(DEPTH - SKID));
    ready_en_d    = 1'b1;
    if (issue) mc_out_d = req_head;
    case ({ld_go, rsp_dec})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mc_out_q      <= '0;
      outstanding_q <= '0;
      rsp_stall_q   <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      mc_out_q      <= mc_out_d;
      outstanding_q <= outstanding_d;
      rsp_stall_q   <= rsp_stall_d;
      ready_en_q    <= ready_en_d;
    end
  end

  assign mc_req_ld        = mc_out_q.ld && !reset;
  assign mc_req_st        = mc_out_q.st && !reset;
  assign mc_req_size      = reset ? 2'b00 : mc_out_q.size;
  assign mc_req_vadr      = reset ? '0 : mc_out_q.vadr;
  assign mc_req_wrd_rdctl = reset ? '0 : mc_out_q.data;
  assign mc_rsp_stall     = rsp_stall_q && !reset;

  assign idle = req_empty && (outstanding_q == '0) && rsp_empty &&
                !mc_out_q.ld && !mc_out_q.st;

  a_rsp_overflow: assert property (@(posedge clock) disable iff (reset)
    !(mc_rsp_push && rsp_full && !rsp_pop));

  a_outstanding_underflow: assert property (@(posedge clock) disable iff (reset)
    !(mc_rsp_push && (outstanding_q == '0)));

endmodule

// File: tb/tb_mc_port_buffer.sv
// Randomised and directed bench for mc_port_buffer against a queue-based model.
module tb_mc_port_buffer;
  import mc_port_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int SKID  = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid, req_ready, req_ld, req_st;
  logic [1:0]         req_size;
  logic [47:0]        req_vadr;
  logic [63:0]        req_data;
  logic               mc_req_ld, mc_req_st;
  logic [1:0]         mc_req_size;
  logic [47:0]        mc_req_vadr;
  logic [63:0]        mc_req_wrd_rdctl;
  logic               mc_rd_rq_stall, mc_wr_rq_stall;
  logic               mc_rsp_push;
  logic [63:0]        mc_rsp_data;
  logic [31:0]        mc_rsp_rdctl;
  logic               mc_rsp_stall, rsp_valid, rsp_ready;
  logic [63:0]        rsp_data;
  logic [31:0]        rsp_rdctl;
  logic               idle;

  always #5 clock = ~clock;

  mc_port_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ld(req_ld), .req_st(req_st),
    .req_size(req_size), .req_vadr(req_vadr), .req_data(req_data),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_size(mc_req_size),
    .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_data(mc_rsp_data), .mc_rsp_rdctl(mc_rsp_rdctl),
    .mc_rsp_stall(mc_rsp_stall), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rdctl(rsp_rdctl), .idle(idle)
  );

  typedef struct {
    bit        ld;
    bit [1:0]  size;
    bit [47:0] vadr;
    bit [63:0] data;
  } mreq_t;

  // Model state: requests waiting, responses buffered, loads the MC still owes.
  mreq_t       drv_q[$];
  mreq_t       m_req_q[$];
  logic [95:0] m_rsp_q[$];
  logic [31:0] mc_pend[$];
  int          m_out;
  bit          m_ready_en;
  bit          m_mc_valid;
  mreq_t       m_mc;
  bit          m_stall;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ld_seen = 0;
  int n_st_seen = 0;
  bit seen_q[$];
  int push_pct = 0, ready_pct = 0, rd_stall_pct = 0, wr_stall_pct = 0, req_pct = 100;

  function automatic bit roll(int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic mreq_t mk_req(bit ld, bit [1:0] size, bit [47:0] vadr, bit [63:0] data);
    mreq_t r;
    r.ld = ld; r.size = size; r.vadr = vadr; r.data = data;
    return r;
  endfunction

  function automatic mreq_t rand_req();
    bit [63:0] a = {$urandom, $urandom};
    bit [63:0] d = {$urandom, $urandom};
    return mk_req(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), a[47:0], d);
  endfunction

  task automatic drive();
    if (drv_q.size() > 0 && roll(req_pct)) begin
      req_valid = 1'b1; req_ld = drv_q[0].ld; req_st = !drv_q[0].ld;
      req_size = drv_q[0].size; req_vadr = drv_q[0].vadr; req_data = drv_q[0].data;
    end else begin
      req_valid = 1'b0; req_ld = 1'b0; req_st = 1'b0;
      req_size = 2'($urandom_range(3, 0)); req_vadr = 48'($urandom); req_data = {$urandom, $urandom};
    end
    mc_rsp_push    = (m_out > 0) && roll(push_pct);
    mc_rsp_data    = {$urandom, $urandom};
    mc_rsp_rdctl   = (mc_pend.size() > 0) ? mc_pend[0] : $urandom;
    rsp_ready      = roll(ready_pct);
    mc_rd_rq_stall = roll(rd_stall_pct);
    mc_wr_rq_stall = roll(wr_stall_pct);
  endtask

  // Advances the model across one rising edge using the inputs applied at that edge.
  task automatic model_step();
    bit    ready, issue, rpop;
    mreq_t head;
    if (reset) begin
      m_req_q.delete(); m_rsp_q.delete(); mc_pend.delete();
      m_out = 0; m_ready_en = 0; m_mc_valid = 0; m_stall = 0;
      return;
    end
    ready = m_ready_en && (m_req_q.size() < DEPTH);
    issue = 0;
    head  = mk_req(0, 0, 0, 0);
    if (m_req_q.size() > 0) begin
      head = m_req_q[0];
      if (head.ld) issue = !mc_rd_rq_stall && (m_out + m_rsp_q.size() < DEPTH);
      else         issue = !mc_wr_rq_stall;
    end
    rpop       = (m_rsp_q.size() > 0) && rsp_ready;
    m_stall    = m_rsp_q.size() >= DEPTH - SKID;
    m_mc_valid = issue;
    m_mc       = head;
    if (issue) begin
      void'(m_req_q.pop_front());
      if (head.ld) begin
        m_out++;
        mc_pend.push_back(head.data[31:0]);
      end
    end
    if (rpop) void'(m_rsp_q.pop_front());
    if (mc_rsp_push) begin
      m_rsp_q.push_back({mc_rsp_rdctl, mc_rsp_data});
      m_out--;
      void'(mc_pend.pop_front());
    end
    if (req_valid && ready) begin
      m_req_q.push_back(mk_req(req_ld, req_size, req_vadr, req_data));
      void'(drv_q.pop_front());
    end
    m_ready_en = 1;
  endtask

  task automatic compare();
    bit ld_e, st_e;
    ld_e = !reset && m_mc_valid && m_mc.ld;
    st_e = !reset && m_mc_valid && !m_mc.ld;
    chk("req_ready", 64'(req_ready), 64'(!reset && m_ready_en && (m_req_q.size() < DEPTH)));
    chk("mc_req_ld", 64'(mc_req_ld), 64'(ld_e));
    chk("mc_req_st", 64'(mc_req_st), 64'(st_e));
    chk("mc_req_size", 64'(mc_req_size), (ld_e || st_e) ? 64'(m_mc.size) : 64'd0);
    chk("mc_req_vadr", 64'(mc_req_vadr), (ld_e || st_e) ? 64'(m_mc.vadr) : 64'd0);
    chk("mc_req_wrd", mc_req_wrd_rdctl, (ld_e || st_e) ? m_mc.data : 64'd0);
    chk("mc_rsp_stall", 64'(mc_rsp_stall), 64'(!reset && m_stall));
    chk("rsp_valid", 64'(rsp_valid), 64'(!reset && (m_rsp_q.size() > 0)));
    if (!reset && m_rsp_q.size() > 0) begin
      chk("rsp_data", rsp_data, m_rsp_q[0][63:0]);
      chk("rsp_rdctl", 64'(rsp_rdctl), 64'(m_rsp_q[0][95:64]));
    end
    if (!reset)
      chk("idle", 64'(idle), 64'(m_req_q.size() == 0 && m_out == 0 &&
                                 m_rsp_q.size() == 0 && !m_mc_valid));
    if (mc_req_ld) begin n_ld_seen++; seen_q.push_back(1'b1); end
    if (mc_req_st) begin n_st_seen++; seen_q.push_back(1'b0); end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    compare();
  endtask

  task automatic run(int n);
    repeat (n) begin drive(); tick(); end
  endtask

  task automatic do_reset();
    push_pct = 0; ready_pct = 0; rd_stall_pct = 0; wr_stall_pct = 0; req_pct = 100;
    drv_q.delete();
    reset = 1'b1;
    drive(); tick();
    reset = 1'b0;
    run(2);
  endtask

  initial begin
    int first_stall, n_pop, n0, st_count;
    req_valid = 0; req_ld = 0; req_st = 0; req_size = 0; req_vadr = 0; req_data = 0;
    mc_rd_rq_stall = 0; mc_wr_rq_stall = 0; mc_rsp_push = 0; mc_rsp_data = 0;
    mc_rsp_rdctl = 0; rsp_ready = 0;
    m_out = 0; m_ready_en = 0; m_mc_valid = 0; m_stall = 0; m_mc = mk_req(0, 0, 0, 0);

    // Reset state.
    drive(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    drive(); tick();
    chk("rst_ready_after", 64'(req_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);

    // Eight back-to-back loads: strobes on cycles 2..9 after the first request.
    do_reset();
    for (int i = 0; i < 8; i++) drv_q.push_back(mk_req(1, 2'd3, 48'h1000 + 48'(8 * i), 64'(i)));
    n0 = 0;
    for (int j = 0; j < 12; j++) begin
      drive(); tick();
      if (mc_req_ld) begin
        chk("t1_ld_cycle", 64'(j + 1), 64'(n0 + 2));
        chk("t1_ld_vadr", 64'(mc_req_vadr), 64'h1000 + 64'(8 * n0));
        n0++;
      end
    end
    chk("t1_ld_count", 64'(n0), 64'd8);
    chk("t1_model_out", 64'(m_out), 64'd8);
    chk("t1_busy", 64'(idle), 64'd0);
    push_pct = 100; ready_pct = 100; run(20);
    chk("t1_idle", 64'(idle), 64'd1);

    // Store held back by five cycles of write stall.
    do_reset();
    drv_q.push_back(mk_req(0, 2'd2, 48'h2000, 64'hDEAD_BEEF));
    st_count = 0;
    for (int j = 0; j < 10; j++) begin
      wr_stall_pct = (j < 5) ? 100 : 0;
      drive(); tick();
      if (mc_req_st) begin
        st_count++;
        chk("t2_st_cycle", 64'(j + 1), 64'd6);
        chk("t2_st_wrd", mc_req_wrd_rdctl, 64'hDEAD_BEEF);
        chk("t2_st_vadr", 64'(mc_req_vadr), 64'h2000);
      end
    end
    chk("t2_st_count", 64'(st_count), 64'd1);

    // Sixteen responses with downstream blocked: stall after count reaches ten.
    do_reset();
    for (int i = 0; i < 16; i++) drv_q.push_back(mk_req(1, 2'd3, 48'h3000 + 48'(8 * i), 64'(i)));
    run(20);
    chk("t3_model_out", 64'(m_out), 64'd16);
    push_pct = 100; first_stall = -1;
    for (int k = 1; k <= 20; k++) begin
      drive(); tick();
      if (mc_rsp_stall && first_stall < 0) first_stall = k;
    end
    chk("t3_stall_at", 64'(first_stall), 64'd11);
    chk("t3_model_buf", 64'(m_rsp_q.size()), 64'd16);
    push_pct = 0; ready_pct = 100; n_pop = 0;
    for (int k = 0; k < 20; k++) begin
      drive();
      if (rsp_valid) begin
        chk("t3_rdctl", 64'(rsp_rdctl), 64'(n_pop));
        n_pop++;
      end
      tick();
    end
    chk("t3_pops", 64'(n_pop), 64'd16);

    // Twenty loads, prompt responses, downstream blocked: issue stops at sixteen.
    do_reset();
    for (int i = 0; i < 20; i++) drv_q.push_back(mk_req(1, 2'd0, 48'h4000 + 48'(i), 64'(i)));
    push_pct = 100; n0 = n_ld_seen;
    run(60);
    chk("t4_halt", 64'(n_ld_seen - n0), 64'd16);
    chk("t4_model_buf", 64'(m_rsp_q.size()), 64'd16);
    ready_pct = 100; drive(); tick();
    ready_pct = 0; run(10);
    chk("t4_one_more", 64'(n_ld_seen - n0), 64'd17);
    ready_pct = 100; run(40);
    chk("t4_all", 64'(n_ld_seen - n0), 64'd20);
    chk("t4_idle", 64'(idle), 64'd1);

    // Load at head under read stall blocks the store behind it.
    do_reset();
    rd_stall_pct = 100;
    drv_q.push_back(mk_req(1, 2'd1, 48'h5000, 64'h55));
    drv_q.push_back(mk_req(0, 2'd1, 48'h5008, 64'h66));
    seen_q.delete();
    run(10);
    chk("t5_blocked", 64'(seen_q.size()), 64'd0);
    rd_stall_pct = 0; run(4);
    chk("t5_count", 64'(seen_q.size()), 64'd2);
    if (seen_q.size() == 2) begin
      chk("t5_first_ld", 64'(seen_q[0]), 64'd1);
      chk("t5_second_st", 64'(seen_q[1]), 64'd0);
    end
    push_pct = 100; ready_pct = 100; run(10);

    // Reset with requests queued and responses buffered.
    do_reset();
    push_pct = 100;
    drv_q.push_back(mk_req(1, 2'd3, 48'h6000, 64'h1));
    drv_q.push_back(mk_req(1, 2'd3, 48'h6008, 64'h2));
    run(10);
    chk("t6_model_buf", 64'(m_rsp_q.size()), 64'd2);
    push_pct = 0; rd_stall_pct = 100; wr_stall_pct = 100;
    for (int i = 0; i < 4; i++) drv_q.push_back(mk_req(i[0], 2'd2, 48'h7000 + 48'(i), 64'(i)));
    run(8);
    chk("t6_model_req", 64'(m_req_q.size()), 64'd4);
    reset = 1'b1; drive(); tick();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0; drv_q.delete();
    n0 = n_ld_seen + n_st_seen;
    run(3);
    chk("t6_idle", 64'(idle), 64'd1);
    chk("t6_no_strobe", 64'(n_ld_seen + n_st_seen - n0), 64'd0);

    // Randomised traffic with occasional mid-stream resets.
    for (int seg = 0; seg < 30; seg++) begin
      if (seg == 10 || seg == 20) do_reset();
      push_pct     = int'($urandom_range(90, 20));
      ready_pct    = int'($urandom_range(100, 10));
      rd_stall_pct = int'($urandom_range(50, 0));
      wr_stall_pct = int'($urandom_range(50, 0));
      req_pct      = int'($urandom_range(100, 30));
      for (int c = 0; c < 100; c++) begin
        if (drv_q.size() < 4) drv_q.push_back(rand_req());
        drive(); tick();
      end
    end
    push_pct = 100; ready_pct = 100; rd_stall_pct = 0; wr_stall_pct = 0; req_pct = 100;
    run(200);
    chk("final_idle", 64'(idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
